// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem req/ack, prefetch FIFO feeding the IF register,
// with branch redirect that drops any in-flight response.
module fetch_unit #(
    parameter int                    WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_addr,
    output logic                  imem_req,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [WORD_WIDTH-1:0] imem_rdata,
    output logic [WORD_WIDTH-1:0] pc,
    output logic [WORD_WIDTH-1:0] instruction,
    output logic                  valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] instr;
    } entry_t;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DISCARD = 2'd2} state_t;

    state_t                state, next_state;
    entry_t                fifo [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count, next_count;
    logic [WORD_WIDTH-1:0] fetch_pc, next_addr, launch_addr;
    logic                  ack, push, pop, launch;

    // An ack is only meaningful while a request is outstanding.
    assign ack        = imem_ack && (state != IDLE);
    assign next_addr  = imem_addr + WORD_WIDTH'(4);
    assign push       = (state == REQ) && imem_ack && !branch_taken;
    assign pop        = valid && !freeze && !branch_taken;
    assign next_count = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // A request is never withdrawn: a branch without an ack parks in DISCARD.
    always_comb begin
        next_state  = state;
        launch      = 1'b0;
        launch_addr = fetch_pc;
        if (branch_taken) begin
            launch_addr = branch_addr;
            if (state == IDLE || ack) begin
                next_state = REQ;
                launch     = 1'b1;
            end else begin
                next_state = DISCARD;
            end
        end else if (state == IDLE || ack) begin
            if (state == REQ) launch_addr = next_addr;
            if (next_count < DEPTH_C) begin
                next_state = REQ;
                launch     = 1'b1;
            end else begin
                next_state = IDLE;
            end
        end
    end

    always_comb begin
        imem_req    = (state != IDLE);
        valid       = (count != '0);
        pc          = valid ? fifo[rd_ptr].pc    : '0;
        instruction = valid ? fifo[rd_ptr].instr : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            imem_addr <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (branch_taken)  fetch_pc <= branch_addr;
            else if (push)     fetch_pc <= next_addr;
            if (launch) imem_addr <= launch_addr;
            if (branch_taken) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= next_count;
            end
        end
    end

    // Storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{pc: next_addr, instr: imem_rdata};
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: latency-configurable memory model plus a scoreboard
// queue of expected FIFO entries, checked against pc/instruction/valid every cycle.
module tb_fetch_unit;
    localparam logic [31:0] PAT = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0, branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] pc, instruction;
    logic        valid;

    fetch_unit #(.WORD_WIDTH(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc),
        .instruction(instruction), .valid(valid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
    exp_t        q[$];
    int          n_checks = 0, n_errors = 0;
    int          lat = 0, waitc = 0;
    bit          stale = 0;
    logic [31:0] exp_req = '0, cur_addr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: memory model answers, inputs are driven, outputs checked, scoreboard advanced.
    task automatic step(input bit f, input bit b, input logic [31:0] ba);
        bit ack_v;
        @(negedge clk);
        ack_v = 0;
        if (imem_req) begin
            if (waitc == 0) begin
                chk("req_addr", imem_addr, exp_req);
                cur_addr = exp_req;
            end else begin
                chk("addr_stable", imem_addr, cur_addr);
            end
            if (waitc == lat) begin ack_v = 1; waitc = 0; end
            else waitc++;
        end else begin
            waitc = 0;
        end
        imem_ack     = ack_v;
        imem_rdata   = ack_v ? (cur_addr ^ PAT) : 32'hDEAD_BEEF;
        freeze       = f;
        branch_taken = b;
        branch_addr  = ba;
        #1;
        if (q.size() == 0) begin
            chk("valid_empty", {31'b0, valid}, 32'd0);
            chk("pc_bubble", pc, 32'd0);
            chk("ins_bubble", instruction, 32'd0);
        end else begin
            chk("valid", {31'b0, valid}, 32'd1);
            chk("pc", pc, q[0].pc);
            chk("ins", instruction, q[0].ins);
            if (!f && !b) void'(q.pop_front());
        end
        if (b) begin
            q.delete();
            stale   = imem_req && !ack_v;
            exp_req = ba;
        end else if (ack_v) begin
            if (stale) stale = 0;
            else begin
                q.push_back('{pc: cur_addr + 32'd4, ins: cur_addr ^ PAT});
                exp_req = cur_addr + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        imem_ack = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_ins", instruction, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        q.delete(); stale = 0; waitc = 0; exp_req = 32'h0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_req(input logic [31:0] a, input bit any);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (imem_req === 1'b1 && (any || imem_addr == a)) found = 1;
            else step(0, 0, 0);
        end
        chk("wait_req", {31'b0, found}, 32'd1);
    endtask

    initial begin
        #2;
        chk("init_req", {31'b0, imem_req}, 32'd0);
        chk("init_valid", {31'b0, valid}, 32'd0);
        chk("init_pc", pc, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // zero-wait streaming
        lat = 0;
        for (int i = 0; i < 30; i++) step(0, 0, 0);

        // 3-cycle ack latency
        lat = 3;
        for (int i = 0; i < 40; i++) step(0, 0, 0);

        // freeze from reset with zero-wait memory
        do_reset();
        lat = 0;
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        @(negedge clk);
        chk("frz_req_idle", {31'b0, imem_req}, 32'd0);
        chk("frz_pc", pc, 32'd4);
        chk("frz_ins", instruction, 32'h0 ^ PAT);
        chk("frz_depth", q.size(), 32'd2);
        for (int i = 0; i < 12; i++) step(0, 0, 0);

        // branch while request to 0x8 is waiting on ack
        do_reset();
        lat = 3;
        wait_req(32'h8, 0);
        step(0, 0, 0);
        step(0, 1, 32'h100);
        @(negedge clk);
        chk("discard_req", {31'b0, imem_req}, 32'd1);
        chk("discard_addr", imem_addr, 32'h8);
        for (int i = 0; i < 20; i++) step(0, 0, 0);

        // branch coinciding with ack and freeze
        lat = 0;
        wait_req(32'h0, 1);
        step(1, 1, 32'h200);
        for (int i = 0; i < 10; i++) step(0, 0, 0);

        // branch near the top of the address space: wraparound
        step(0, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 10; i++) step(0, 0, 0);

        // reset mid-request
        lat = 3;
        wait_req(32'h0, 1);
        do_reset();
        for (int i = 0; i < 15; i++) step(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
